// File: rtl/axi_lite_lsu.sv
// Load/store unit: one EXU request at a time, run as a single AXI4-Lite read or write.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned accesses fail without bus traffic.
module axi_lite_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int NBYTE = DATA_W / 8;
    localparam int OFS_W = $clog2(NBYTE);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RESP} state_t;

    state_t              state, state_next;
    logic                wen_q, sext_q;
    logic [1:0]          size_q;
    logic [OFS_W-1:0]    ofs_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                aw_done_q, w_done_q, aw_done_next, w_done_next;
    logic [DATA_W-1:0]   rdata_q, rdata_next;
    logic                err_q, err_next;

    logic [OFS_W-1:0]    low_mask;
    logic                size_bad, reject;
    logic [DATA_W-1:0]   rd_shift, load_ext;
    logic                sign;
    logic [NBYTE-1:0]    strb_base;

    // Offset bits below the access size; nonzero there means misaligned.
    always_comb begin
        low_mask = '0;
        for (int i = 0; i < OFS_W; i++) low_mask[i] = (i < int'(req_size));
    end

    assign size_bad = (DATA_W == 32) && (req_size == 2'd3);

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign = |(req_addr[OFS_W-1:0] & low_mask);
    assign reject   = size_bad | misalign;
`else
    assign reject   = size_bad;
`endif

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            wen_q   <= req_wen;
            sext_q  <= req_sext;
            size_q  <= req_size;
            ofs_q   <= req_addr[OFS_W-1:0] & ~low_mask;
            addr_q  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            wdata_q <= req_wdata;
        end
    end

    // Read lane extraction and sign/zero extension.
    assign rd_shift = rdata >> {ofs_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    sign = rd_shift[7];
            2'd1:    sign = rd_shift[15];
            2'd2:    sign = rd_shift[31];
            default: sign = rd_shift[DATA_W-1];
        endcase
        load_ext = '0;
        for (int i = 0; i < DATA_W; i++)
            load_ext[i] = (i < (8 << size_q)) ? rd_shift[i] : (sext_q & sign);
    end

    always_comb begin
        strb_base = '0;
        for (int i = 0; i < NBYTE; i++) strb_base[i] = (i < (1 << size_q));
    end

    assign wstrb = strb_base << ofs_q;
    assign wdata = wdata_q << {ofs_q, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            aw_done_q <= aw_done_next;
            w_done_q  <= w_done_next;
            rdata_q   <= rdata_next;
            err_q     <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        rdata_next   = rdata_q;
        err_next     = err_q;
        aw_done_next = aw_done_q;
        w_done_next  = w_done_q;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_next   = '0;
                    err_next     = reject;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    if (reject)       state_next = S_RESP;
                    else if (req_wen) state_next = S_AWW;
                    else              state_next = S_AR;
                end
            end
            S_AR: if (arready) state_next = S_R;
            S_R: begin
                if (rvalid) begin
                    rdata_next = (rresp == 2'b00) ? load_ext : '0;
                    err_next   = (rresp != 2'b00);
                    state_next = S_RESP;
                end
            end
            S_AWW: begin
                aw_done_next = aw_done_q | awready;
                w_done_next  = w_done_q | wready;
                if (aw_done_next && w_done_next) state_next = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    err_next   = (bresp != 2'b00);
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign arvalid    = (state == S_AR);
    assign rready     = (state == S_R);
    assign awvalid    = (state == S_AWW) && !aw_done_q;
    assign wvalid     = (state == S_AWW) && !w_done_q;
    assign bready     = (state == S_B);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // wen_q is kept for debug visibility of the latched request.
    logic unused_ok;
    assign unused_ok = wen_q;
endmodule

// File: tb/tb_axi_lite_lsu.sv
// Directed bench for axi_lite_lsu: a 32-bit and a 64-bit instance against hand-computed vectors.
module tb_axi_lite_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 32-bit instance
    logic        req_valid, req_ready, req_wen, req_sext, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata, araddr, rdata, awaddr, wdata;
    logic [1:0]  req_size, rresp, bresp;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    axi_lite_lsu #(.ADDR_W(32), .DATA_W(32)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_sext(req_sext), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready));

    // 64-bit instance
    logic        d_req_valid, d_req_ready, d_req_wen, d_req_sext, d_resp_valid, d_resp_err;
    logic [31:0] d_req_addr, d_araddr, d_awaddr;
    logic [63:0] d_req_wdata, d_resp_rdata, d_rdata, d_wdata;
    logic [1:0]  d_req_size, d_rresp, d_bresp;
    logic        d_arvalid, d_arready, d_rvalid, d_rready, d_awvalid, d_awready;
    logic        d_wvalid, d_wready, d_bvalid, d_bready;
    logic [7:0]  d_wstrb;

    axi_lite_lsu #(.ADDR_W(32), .DATA_W(64)) u64 (
        .clk(clk), .rst(rst), .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen),
        .req_addr(d_req_addr), .req_size(d_req_size), .req_sext(d_req_sext), .req_wdata(d_req_wdata),
        .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
        .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready), .rdata(d_rdata), .rresp(d_rresp),
        .rvalid(d_rvalid), .rready(d_rready), .awaddr(d_awaddr), .awvalid(d_awvalid),
        .awready(d_awready), .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
        .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 32-bit transaction; slave readies follow aw_d / w_d, read side is zero-wait.
    task automatic txn(input string tag, input logic wen, input logic [31:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rr,
                       input logic [1:0] br, input int aw_d, input int w_d, input logic bus,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_strb,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat);
        int pulses = 0, lat = -1;
        logic seen_bus = 1'b0, g_err = 1'b0;
        logic [31:0] g_addr = '0, g_wdata = '0, g_rdata = '0;
        logic [3:0] g_strb = '0;
        chk({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_size = sz; req_sext = sx; req_wdata = wd;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rdata = rd; rresp = rr; bresp = br;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = ~wen; req_addr = '1; req_sext = ~sx; req_wdata = '1;
        for (int n = 0; n < 12; n++) begin
            if (resp_valid) begin pulses++; if (lat < 0) lat = n; g_rdata = resp_rdata; g_err = resp_err; end
            if (arvalid) begin seen_bus = 1'b1; g_addr = araddr; end
            if (awvalid) begin seen_bus = 1'b1; g_addr = awaddr; end
            if (wvalid)  begin seen_bus = 1'b1; g_wdata = wdata; g_strb = wstrb; end
            arready = 1'b1; rvalid = 1'b1; bvalid = 1'b1;
            awready = (n >= aw_d); wready = (n >= w_d);
            @(posedge clk); #1;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_rdata"}, g_rdata, e_rdata);
        chk({tag, "_err"}, g_err, e_err);
        chk({tag, "_bus"}, seen_bus, bus);
        if (bus) chk({tag, "_addr"}, g_addr, e_addr);
        if (bus && wen) begin
            chk({tag, "_wdata"}, g_wdata, e_wdata);
            chk({tag, "_wstrb"}, g_strb, e_strb);
        end
    endtask

    task automatic txn64(input string tag, input logic wen, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [63:0] wd, input logic [63:0] rd, input logic [1:0] br,
                         input logic [31:0] e_addr, input logic [63:0] e_wdata, input logic [7:0] e_strb,
                         input logic [63:0] e_rdata, input logic e_err);
        int pulses = 0;
        logic g_err = 1'b0;
        logic [31:0] g_addr = '0;
        logic [63:0] g_wdata = '0, g_rdata = '0;
        logic [7:0] g_strb = '0;
        d_req_valid = 1'b1; d_req_wen = wen; d_req_addr = a; d_req_size = sz; d_req_sext = sx;
        d_req_wdata = wd; d_rdata = rd; d_rresp = 2'b00; d_bresp = br;
        @(posedge clk); #1;
        d_req_valid = 1'b0; d_req_addr = '1; d_req_wdata = '1;
        for (int n = 0; n < 10; n++) begin
            if (d_resp_valid) begin pulses++; g_rdata = d_resp_rdata; g_err = d_resp_err; end
            if (d_arvalid) g_addr = d_araddr;
            if (d_awvalid) g_addr = d_awaddr;
            if (d_wvalid) begin g_wdata = d_wdata; g_strb = d_wstrb; end
            d_arready = 1; d_rvalid = 1; d_awready = 1; d_wready = 1; d_bvalid = 1;
            @(posedge clk); #1;
        end
        d_arready = 0; d_rvalid = 0; d_awready = 0; d_wready = 0; d_bvalid = 0;
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_addr"}, g_addr, e_addr);
        chk({tag, "_rdata"}, g_rdata, e_rdata);
        chk({tag, "_err"}, g_err, e_err);
        if (wen) begin
            chk({tag, "_wdata"}, g_wdata, e_wdata);
            chk({tag, "_wstrb"}, g_strb, e_strb);
        end
    endtask

    initial begin
        int n, pulses;
        req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_sext = 0; req_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        d_req_valid = 0; d_req_wen = 0; d_req_addr = 0; d_req_size = 0; d_req_sext = 0; d_req_wdata = 0;
        d_arready = 0; d_rvalid = 0; d_rdata = 0; d_rresp = 0; d_awready = 0; d_wready = 0;
        d_bvalid = 0; d_bresp = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 6'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst64_valids", {d_arvalid, d_awvalid, d_wvalid, d_resp_valid, d_req_ready}, 5'b00001);

        //   tag      wen addr          sz sx wdata         rdata         rr br aw w bus eaddr         ewdata        strb     erdata        err lat
        txn("lw",     0, 32'h8000_0004, 2, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h8000_0004, 32'h0,        4'b0000, 32'hDEAD_BEEF, 0, 2);
        txn("lb_s",   0, 32'h8000_0003, 0, 1, 32'h0,        32'h8012_3456, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_FF80, 0, 2);
        txn("lhu",    0, 32'h8000_0002, 1, 0, 32'h0,        32'hABCD_1234, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_ABCD, 0, 2);
        txn("lh_s",   0, 32'h8000_0012, 1, 1, 32'h0,        32'h8001_7777, 0, 0, 0, 0, 1, 32'h8000_0010, 32'h0,        4'b0000, 32'hFFFF_8001, 0, 2);
        txn("lbu",    0, 32'h8000_0001, 0, 0, 32'h0,        32'h0000_C300, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_00C3, 0, 2);
        txn("lw_err", 0, 32'h8000_0008, 2, 0, 32'h0,        32'h1234_5678, 2, 0, 0, 0, 1, 32'h8000_0008, 32'h0,        4'b0000, 32'h0,        1, 2);
        txn("sh",     1, 32'h0000_1002, 1, 0, 32'h0000_1234, 32'h0,       0, 0, 0, 2, 1, 32'h0000_1000, 32'h1234_0000, 4'b1100, 32'h0,        0, 4);
        txn("sb",     1, 32'h0000_1003, 0, 0, 32'h0000_00A5, 32'h0,       0, 0, 3, 0, 1, 32'h0000_1000, 32'hA500_0000, 4'b1000, 32'h0,        0, 5);
        txn("sw_err", 1, 32'h0000_2004, 2, 0, 32'h5566_7788, 32'h0,       0, 3, 0, 0, 1, 32'h0000_2004, 32'h5566_7788, 4'b1111, 32'h0,        1, 2);
        txn("bad_sz", 0, 32'h0000_2000, 3, 0, 32'h0,        32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        txn("mis_lw", 0, 32'h0000_2001, 2, 0, 32'h0,        32'h1122_3344, 0, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 0);
        txn("mis_sh", 1, 32'h0000_2003, 1, 0, 32'h0000_1234, 32'h0,       0, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 0);
`else
        txn("mis_lw", 0, 32'h0000_2001, 2, 0, 32'h0,        32'h1122_3344, 0, 0, 0, 0, 1, 32'h0000_2000, 32'h0,        4'b0000, 32'h1122_3344, 0, 2);
        txn("mis_sh", 1, 32'h0000_2003, 1, 0, 32'h0000_1234, 32'h0,       0, 0, 0, 0, 1, 32'h0000_2000, 32'h1234_0000, 4'b1100, 32'h0,        0, 2);
`endif

        // Reset while waiting in R with rvalid stuck low.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h3000_0008; req_size = 2'd2; req_sext = 1'b0;
        arready = 1'b1; rvalid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rready && n < 10) begin @(posedge clk); #1; n++; end
        chk("rst_mid_in_r", rready, 1'b1);
        arready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_rready", rready, 1'b0);
        chk("rst_mid_req_ready", req_ready, 1'b1);
        chk("rst_mid_arvalid", arvalid, 1'b0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_resp", pulses, 0);
        txn("lw_after", 0, 32'h3000_0008, 2, 0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 1, 32'h3000_0008, 32'h0, 4'b0000, 32'hCAFE_F00D, 0, 2);

        // 64-bit bus
        txn64("sd", 1, 32'h8000_0008, 3, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 2,
              32'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1);
        txn64("lw64_s", 0, 32'h8000_0014, 2, 1, 64'h0, 64'h8765_4321_0000_0000, 0,
              32'h8000_0010, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 0);
        txn64("sh64", 1, 32'h8000_0006, 1, 0, 64'h0000_0000_0000_BEEF, 64'h0, 0,
              32'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0, 0);
        txn64("ld", 0, 32'h8000_0020, 3, 0, 64'h0, 64'hFEDC_BA98_7654_3210, 0,
              32'h8000_0020, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
